uart_tx_fifo: RTL and testbench

Parametrised UART transmitter: the successor to the fixed 8N1, 68 MHz / 115200 transmitter. It adds configurable clock/baud ratio, data width, parity and stop bits, plus a small transmit FIFO so the host can queue bytes without waiting for the line. It sits between the system-bus write strobe and the serial TX pin, and is clocked entirely from the system clock.

---
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable baud ratio, frame format and a small write FIFO.
// Bit timing comes from a fractional accumulator, so tick spacing never drifts.
//
// state | meaning
// IDLE  | line high, accumulator held at zero, waiting for a queued word
// START | start bit (low) on the line
// DATA  | data bits shifting out, LSB first
// PAR   | parity bit on the line
// STOP  | stop bit(s) high; pops the next word on the final tick
module uart_tx_fifo #(
  parameter int CLK_HZ     = 68000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               sys_clk_i,
  input  logic                               sys_rst_i,
  input  logic                               uart_wr_i,
  input  logic [DATA_BITS-1:0]               uart_dat_i,
  output logic                               uart_tx_o,
  output logic                               uart_busy_o,
  output logic                               uart_full_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    uart_lvl_o,
  output logic                               uart_ovf_o
);

  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 state, state_nxt;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       lvl_nxt;
  logic                   push, pop, shift, not_empty;
  logic [DATA_BITS-1:0]   head, shreg;
  logic                   par_q, tx_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   stop_cnt;
  logic [ACC_W-1:0]       acc, acc_sum;
  logic                   tick, last_bit, last_stop;

  // Full is the registered flag, so a pop in the same cycle never makes room.
  assign push      = uart_wr_i & ~uart_full_o;
  assign not_empty = (uart_lvl_o != '0);
  assign head      = mem[rd_ptr];

  always_comb begin
    lvl_nxt = uart_lvl_o;
    if (push && !pop)
      lvl_nxt = uart_lvl_o + LVL_W'(1);
    else if (!push && pop)
      lvl_nxt = uart_lvl_o - LVL_W'(1);
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      uart_lvl_o  <= '0;
      uart_full_o <= 1'b0;
      uart_ovf_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      uart_lvl_o  <= lvl_nxt;
      uart_full_o <= (lvl_nxt == LVL_W'(FIFO_DEPTH));
      if (uart_wr_i && uart_full_o) uart_ovf_o <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wr_ptr] <= uart_dat_i;
  end

  assign acc_sum = acc + ACC_W'(BAUD);
  assign tick    = (state != S_IDLE) && (acc_sum >= ACC_W'(CLK_HZ));

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i)
      acc <= '0;
    else if (state == S_IDLE || state_nxt == S_IDLE)
      acc <= '0;
    else if (tick)
      acc <= acc_sum - ACC_W'(CLK_HZ);
    else
      acc <= acc_sum;
  end

  assign last_bit  = (bit_cnt == CNT_W'(DATA_BITS));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (not_empty) state_nxt = S_START;
      S_START: if (tick) state_nxt = S_DATA;
      S_DATA:  if (tick && last_bit) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (tick) state_nxt = S_STOP;
      S_STOP:  if (tick && last_stop) state_nxt = not_empty ? S_START : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    shift  = 1'b0;
    tx_nxt = uart_tx_o;
    case (state)
      S_IDLE: if (not_empty) begin
        pop    = 1'b1;
        tx_nxt = 1'b0;
      end
      S_START: if (tick) begin
        tx_nxt = shreg[0];
        shift  = 1'b1;
      end
      S_DATA: if (tick) begin
        if (last_bit) begin
          tx_nxt = (PARITY != 0) ? par_q : 1'b1;
        end else begin
          tx_nxt = shreg[0];
          shift  = 1'b1;
        end
      end
      S_PAR: if (tick) tx_nxt = 1'b1;
      S_STOP: if (tick && last_stop) begin
        pop    = not_empty;
        tx_nxt = ~not_empty;
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      uart_tx_o <= 1'b1;
      shreg     <= '0;
      par_q     <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      uart_tx_o <= tx_nxt;
      if (pop) begin
        shreg   <= head;
        par_q   <= (^head) ^ 1'(PARITY == 1);
        bit_cnt <= '0;
      end else if (shift) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (state != S_STOP) stop_cnt <= 1'b0;
      else if (tick)       stop_cnt <= stop_cnt + 1'b1;
    end
  end

  assign uart_busy_o = (state != S_IDLE) | not_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four 160/10 instances (8N1, 8E1, 8O1, 8N2)
// and one instance at the default 68 MHz / 115200 ratio.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr   [5];
  logic [7:0] dat  [5];
  logic       tx   [5];
  logic       busy [5];
  logic       full [5];
  logic       ovf  [5];
  logic [2:0] lvl  [5];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(160), .BAUD(10), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr[0]), .uart_dat_i(dat[0]),
    .uart_tx_o(tx[0]), .uart_busy_o(busy[0]), .uart_full_o(full[0]),
    .uart_lvl_o(lvl[0]), .uart_ovf_o(ovf[0]));
  uart_tx_fifo #(.CLK_HZ(160), .BAUD(10), .PARITY(2), .STOP_BITS(1)) u_e1 (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr[1]), .uart_dat_i(dat[1]),
    .uart_tx_o(tx[1]), .uart_busy_o(busy[1]), .uart_full_o(full[1]),
    .uart_lvl_o(lvl[1]), .uart_ovf_o(ovf[1]));
  uart_tx_fifo #(.CLK_HZ(160), .BAUD(10), .PARITY(1), .STOP_BITS(1)) u_o1 (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr[2]), .uart_dat_i(dat[2]),
    .uart_tx_o(tx[2]), .uart_busy_o(busy[2]), .uart_full_o(full[2]),
    .uart_lvl_o(lvl[2]), .uart_ovf_o(ovf[2]));
  uart_tx_fifo #(.CLK_HZ(160), .BAUD(10), .PARITY(0), .STOP_BITS(2)) u_n2 (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr[3]), .uart_dat_i(dat[3]),
    .uart_tx_o(tx[3]), .uart_busy_o(busy[3]), .uart_full_o(full[3]),
    .uart_lvl_o(lvl[3]), .uart_ovf_o(ovf[3]));
  uart_tx_fifo u_def (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr[4]), .uart_dat_i(dat[4]),
    .uart_tx_o(tx[4]), .uart_busy_o(busy[4]), .uart_full_o(full[4]),
    .uart_lvl_o(lvl[4]), .uart_ovf_o(ovf[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Sends one word and checks the first and last cycle of every 16-cycle bit.
  task automatic send_frame(input int idx, input logic [7:0] d, input int nbits,
                            input logic [15:0] fr, input string tag);
    wr[idx] = 1'b1;
    dat[idx] = d;
    @(negedge clk);
    wr[idx] = 1'b0;
    check({tag, "_lvl_after_wr"}, 32'(lvl[idx]), 1);
    @(negedge clk);
    check({tag, "_lvl_after_pop"}, 32'(lvl[idx]), 0);
    for (int j = 0; j < nbits; j++) begin
      for (int c = 0; c < 16; c++) begin
        if (c == 0 || c == 15)
          check($sformatf("%s_bit%0d_c%0d", tag, j, c), 32'(tx[idx]), 32'(fr[j]));
        if (j == nbits - 1 && c == 15)
          check({tag, "_busy_last"}, 32'(busy[idx]), 1);
        @(negedge clk);
      end
    end
    check({tag, "_busy_end"}, 32'(busy[idx]), 0);
    check({tag, "_tx_end"}, 32'(tx[idx]), 1);
  endtask

  logic [15:0] fr2;
  int          chg [10];
  int          exp_chg [9];
  int          cnt, nchg, len_ok;
  logic        prev, saw_low;

  initial begin
    for (int i = 0; i < 5; i++) begin
      wr[i]  = 1'b0;
      dat[i] = 8'h00;
    end
    exp_chg = '{591, 1181, 1771, 2362, 2952, 3542, 4132, 4723, 5313};
    wait_cyc(3);
    check("rst_tx", 32'(tx[0]), 1);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_full", 32'(full[0]), 0);
    check("rst_lvl", 32'(lvl[0]), 0);
    check("rst_ovf", 32'(ovf[0]), 0);
    check("rst_tx_def", 32'(tx[4]), 1);
    rst = 1'b0;
    wait_cyc(2);

    send_frame(0, 8'hA5, 10, {6'h3f, 1'b1, 8'hA5, 1'b0}, "n1");
    send_frame(1, 8'h03, 11, {5'h1f, 1'b1, 1'b0, 8'h03, 1'b0}, "e1");
    send_frame(2, 8'h03, 11, {5'h1f, 1'b1, 1'b1, 8'h03, 1'b0}, "o1");
    send_frame(3, 8'hFF, 11, {5'h1f, 2'b11, 8'hFF, 1'b0}, "n2");

    // Five back-to-back writes: edge k pushes, edge k+1 pops word 1.
    wr[0] = 1'b1; dat[0] = 8'h11; @(negedge clk);
    check("q_lvl_k", 32'(lvl[0]), 1);
    dat[0] = 8'h22; @(negedge clk);
    check("q_lvl_k1", 32'(lvl[0]), 1);
    check("q_tx_start", 32'(tx[0]), 0);
    dat[0] = 8'h33; @(negedge clk);
    check("q_lvl_k2", 32'(lvl[0]), 2);
    dat[0] = 8'h44; @(negedge clk);
    check("q_lvl_k3", 32'(lvl[0]), 3);
    dat[0] = 8'h55; @(negedge clk);
    wr[0] = 1'b0;
    check("q_lvl_k4", 32'(lvl[0]), 4);
    check("q_full_k4", 32'(full[0]), 1);
    check("q_ovf_k4", 32'(ovf[0]), 0);
    wait_cyc(156);
    check("q_stop_last_tx", 32'(tx[0]), 1);
    check("q_stop_last_lvl", 32'(lvl[0]), 4);
    @(negedge clk);
    check("q_b2b_tx", 32'(tx[0]), 0);
    check("q_b2b_lvl", 32'(lvl[0]), 3);
    check("q_b2b_full", 32'(full[0]), 0);
    check("q_b2b_busy", 32'(busy[0]), 1);
    wr[0] = 1'b1; dat[0] = 8'h66; @(negedge clk);
    wr[0] = 1'b0;
    check("q_refill_lvl", 32'(lvl[0]), 4);
    check("q_refill_full", 32'(full[0]), 1);
    fr2 = {6'h3f, 1'b1, 8'h22, 1'b0};
    wait_cyc(7);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) wait_cyc(16);
      check($sformatf("q_f2_bit%0d", j), 32'(tx[0]), 32'(fr2[j]));
    end
    wait_cyc(7);
    check("q_f2_last_tx", 32'(tx[0]), 1);
    check("q_f2_last_full", 32'(full[0]), 1);
    check("q_f2_last_ovf", 32'(ovf[0]), 0);
    // Write while full, same edge as the pop of word 3.
    wr[0] = 1'b1; dat[0] = 8'h77; @(negedge clk);
    wr[0] = 1'b0;
    check("ovf_set", 32'(ovf[0]), 1);
    check("ovf_lvl", 32'(lvl[0]), 3);
    check("ovf_full", 32'(full[0]), 0);
    check("ovf_tx_start", 32'(tx[0]), 0);

    // Frame 3 (0x33) is now in data bit 3, which is a zero.
    wait_cyc(70);
    check("mid_d3_tx", 32'(tx[0]), 0);
    check("mid_ovf", 32'(ovf[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_tx", 32'(tx[0]), 1);
    check("arst_lvl", 32'(lvl[0]), 0);
    check("arst_busy", 32'(busy[0]), 0);
    check("arst_ovf", 32'(ovf[0]), 0);
    check("arst_full", 32'(full[0]), 0);
    wait_cyc(2);
    rst = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) saw_low = 1'b1;
    end
    check("post_rst_quiet", 32'(saw_low), 0);

    // Default ratio: bit edges at ceil(k*68e6/115200).
    wr[4] = 1'b1; dat[4] = 8'h55; @(negedge clk);
    wr[4] = 1'b0; @(negedge clk);
    check("def_start_tx", 32'(tx[4]), 0);
    for (int i = 0; i < 10; i++) chg[i] = 0;
    cnt = 0; nchg = 0; prev = 1'b0;
    while (busy[4] === 1'b1 && cnt < 7000) begin
      @(negedge clk);
      cnt++;
      if (tx[4] !== prev) begin
        if (nchg < 10) chg[nchg] = cnt;
        nchg++;
        prev = tx[4];
      end
    end
    check("def_stop_end", 32'(cnt), 5903);
    check("def_nchg", 32'(nchg), 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("def_tick%0d", i + 1), 32'(chg[i]), 32'(exp_chg[i]));
    len_ok = 1;
    for (int i = 0; i < 10; i++) begin
      int d;
      d = (i == 9) ? (cnt - chg[8]) : (i == 0 ? chg[0] : chg[i] - chg[i-1]);
      if (d != 590 && d != 591) len_ok = 0;
    end
    check("def_bit_len", 32'(len_ok), 1);
    check("def_tx_idle", 32'(tx[4]), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
